// File: rtl/module_seg_scan.sv
// Time-multiplexed 7-segment scanner for N_DIGITS BCD digits. Words arrive over valid/ready
// and reach the display only at scan-frame boundaries, so a frame never mixes two words.
module module_seg_scan #(
  parameter int N_DIGITS       = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic                  valid,
  output logic                  ready,
  input  logic                  lz_en,
  input  logic                  blank,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   transis,
  output logic                  loaded
);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = $clog2(N_DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] SEL_LAST = SW'(N_DIGITS - 1);
  // XOR masks: all-ones inverts an active-high pattern into active-low form
  localparam logic [6:0]          SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic [N_DIGITS-1:0] AN_OFF  = {N_DIGITS{AN_ACTIVE_LOW}};

  logic [CW-1:0]         cnt_reg;
  logic [SW-1:0]         sel_reg;
  logic                  pend_reg;
  logic                  loaded_reg;
  logic [6:0]            seg_reg;
  logic [N_DIGITS-1:0]   transis_reg;
  logic [4*N_DIGITS-1:0] disp_flat;
  logic                  tick;
  logic                  frame_end;
  logic                  accept;
  logic                  swap;
  logic [N_DIGITS-1:0]   lit_mask;
  logic                  zero_run;
  logic [3:0]            cur_digit;
  logic [6:0]            cur_pattern;
  logic [N_DIGITS-1:0]   cur_onehot;

  function automatic logic [6:0] decode7(input logic [3:0] d);
    case (d)
      4'd0:    decode7 = 7'b1111110;
      4'd1:    decode7 = 7'b0110000;
      4'd2:    decode7 = 7'b1101101;
      4'd3:    decode7 = 7'b1111001;
      4'd4:    decode7 = 7'b0110011;
      4'd5:    decode7 = 7'b1011011;
      4'd6:    decode7 = 7'b1011111;
      4'd7:    decode7 = 7'b1110000;
      4'd8:    decode7 = 7'b1111111;
      4'd9:    decode7 = 7'b1111011;
      default: decode7 = 7'b1001001;
    endcase
  endfunction

  assign tick      = (cnt_reg == CNT_LAST);
  assign frame_end = tick && (sel_reg == SEL_LAST);
  assign accept    = valid && !pend_reg;
  assign swap      = frame_end && pend_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      sel_reg <= '0;
    end else if (tick) begin
      cnt_reg <= '0;
      sel_reg <= (sel_reg == SEL_LAST) ? '0 : sel_reg + 1'b1;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // accept needs pend=0 and swap needs pend=1, so they never collide
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg   <= 1'b0;
      loaded_reg <= 1'b0;
    end else begin
      loaded_reg <= swap;
      if (accept)
        pend_reg <= 1'b1;
      else if (swap)
        pend_reg <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
    logic [3:0] pend_data_reg;
    logic [3:0] disp_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        pend_data_reg <= '0;
        disp_reg      <= '0;
      end else begin
        if (accept)
          pend_data_reg <= digits_in[4*gi +: 4];
        if (swap)
          disp_reg <= pend_data_reg;
      end
    end
    assign disp_flat[4*gi +: 4] = disp_reg;
  end

  // Walk down from the top digit; a digit stays dark while everything above it is zero
  always_comb begin
    lit_mask = '1;
    zero_run = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run && (disp_flat[4*i +: 4] == 4'd0);
      if (zero_run)
        lit_mask[i] = 1'b0;
    end
  end

  assign cur_digit   = disp_flat[4*sel_reg +: 4];
  assign cur_pattern = decode7(cur_digit);
  assign cur_onehot  = N_DIGITS'(1) << sel_reg;

  always_ff @(posedge clk) begin
    if (rst || blank || (lz_en && !lit_mask[sel_reg])) begin
      seg_reg     <= SEG_OFF;
      transis_reg <= AN_OFF;
    end else begin
      seg_reg     <= cur_pattern ^ SEG_OFF;
      transis_reg <= cur_onehot ^ AN_OFF;
    end
  end

  assign ready   = !pend_reg;
  assign loaded  = loaded_reg;
  assign seg     = seg_reg;
  assign transis = transis_reg;
endmodule

// File: tb/tb_module_seg_scan.sv
// Scoreboard bench for module_seg_scan (4 digits, refresh divider 4): stimulus queues
// cycle-stamped expectations, a negedge monitor compares whatever falls due.
module tb_module_seg_scan;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits_in = '0;
  logic        valid = 1'b0;
  logic        ready;
  logic        lz_en = 1'b0;
  logic        blank = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  transis;
  logic        loaded;

  module_seg_scan #(
    .N_DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .valid(valid), .ready(ready),
    .lz_en(lz_en), .blank(blank), .seg(seg), .transis(transis), .loaded(loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [95:0] tag;
    int unsigned at;
    logic [3:0]  tr;
    logic [6:0]  sg;
    logic        chk_rdy;
    logic        rdy;
  } exp_t;

  localparam logic [6:0] OFF = 7'b1111111;

  exp_t        sb[$];
  int unsigned ld_q[$];
  int unsigned cyc = 0;
  int unsigned base = 0;
  int          compared = 0;
  int          mismatched = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: display expectations due this cycle, and every loaded pulse
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        compared++;
        if (transis !== sb[i].tr || seg !== sb[i].sg) begin
          mismatched++;
          $display("FAIL %0s @%0d: transis=%b seg=%b, expected transis=%b seg=%b",
                   sb[i].tag, cyc - base, transis, seg, sb[i].tr, sb[i].sg);
        end
        if (sb[i].chk_rdy) begin
          compared++;
          if (ready !== sb[i].rdy) begin
            mismatched++;
            $display("FAIL %0s_ready @%0d: ready=%b, expected %b", sb[i].tag, cyc - base, ready, sb[i].rdy);
          end
        end
        sb.delete(i);
      end else if (sb[i].at < cyc) begin
        compared++;
        mismatched++;
        $display("FAIL %0s: check at %0d was skipped", sb[i].tag, sb[i].at);
        sb.delete(i);
      end
    end
    while (ld_q.size() > 0 && ld_q[0] < cyc) begin
      compared++;
      mismatched++;
      $display("FAIL loaded_missing: no pulse at cycle %0d", ld_q[0] - base);
      void'(ld_q.pop_front());
    end
    if (loaded === 1'b1) begin
      compared++;
      if (ld_q.size() == 0) begin
        mismatched++;
        $display("FAIL loaded_unexpected: pulse at cycle %0d, expected none", cyc - base);
      end else if (ld_q[0] != cyc) begin
        mismatched++;
        $display("FAIL loaded_timing: pulse at cycle %0d, expected %0d", cyc - base, ld_q[0] - base);
      end else begin
        void'(ld_q.pop_front());
      end
    end
  end

  task automatic push(input logic [95:0] tag, input int k, input logic [3:0] tr,
                      input logic [6:0] sg, input logic chk_rdy, input logic rdy);
    exp_t e;
    e.tag = tag; e.at = base + k; e.tr = tr; e.sg = sg; e.chk_rdy = chk_rdy; e.rdy = rdy;
    sb.push_back(e);
  endtask

  task automatic tick_to(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  // Reset takes effect on the next edge; k counts edges after that one
  task automatic do_reset();
    rst  = 1'b1;
    base = cyc + 1;
    push("rst_state", 0, 4'b0000, OFF, 1'b1, 1'b1);
    tick_to(base);
    rst = 1'b0;
  endtask

  task automatic offer(input int k, input logic [15:0] d, input int hold);
    tick_to(base + k);
    digits_in = d;
    valid     = 1'b1;
    tick_to(base + k + hold);
    valid     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    do_reset();

    // Idle scan of an all-zero display, each slot held 4 cycles
    push("t1_scan", 1,  4'b0001, 7'b0000001, 1'b1, 1'b1);
    push("t1_scan", 4,  4'b0001, 7'b0000001, 1'b0, 1'b0);
    push("t1_scan", 5,  4'b0010, 7'b0000001, 1'b0, 1'b0);
    push("t1_scan", 8,  4'b0010, 7'b0000001, 1'b0, 1'b0);
    push("t1_scan", 9,  4'b0100, 7'b0000001, 1'b0, 1'b0);
    push("t1_scan", 13, 4'b1000, 7'b0000001, 1'b0, 1'b0);
    push("t1_scan", 16, 4'b1000, 7'b0000001, 1'b0, 1'b0);
    push("t1_scan", 17, 4'b0001, 7'b0000001, 1'b0, 1'b0);

    // Accept 1234 at edge 18; frame ends at edge 32
    push("t2_pend", 18, 4'b0001, 7'b0000001, 1'b1, 1'b0);
    push("t2_pend", 31, 4'b1000, 7'b0000001, 1'b1, 1'b0);
    push("t2_swap", 32, 4'b1000, 7'b0000001, 1'b1, 1'b1);
    ld_q.push_back(base + 32);
    push("t2_d4", 33, 4'b0001, 7'b1001100, 1'b0, 1'b0);
    push("t2_d3", 37, 4'b0010, 7'b0000110, 1'b0, 1'b0);
    push("t2_d2", 41, 4'b0100, 7'b0010010, 1'b0, 1'b0);
    push("t2_d1", 45, 4'b1000, 7'b1001111, 1'b0, 1'b0);
    offer(17, 16'h1234, 1);

    // Leading-zero blanking
    tick_to(base + 48);
    lz_en = 1'b1;
    push("t3_nolz", 49, 4'b0001, 7'b1001100, 1'b0, 1'b0);
    ld_q.push_back(base + 64);
    push("t3_d7",   65, 4'b0001, 7'b0001111, 1'b0, 1'b0);
    push("t3_blk1", 69, 4'b0000, OFF, 1'b0, 1'b0);
    push("t3_blk2", 73, 4'b0000, OFF, 1'b0, 1'b0);
    push("t3_blk3", 77, 4'b0000, OFF, 1'b0, 1'b0);
    offer(49, 16'h0007, 1);
    ld_q.push_back(base + 80);
    push("t3_zero", 81, 4'b0001, 7'b0000001, 1'b0, 1'b0);
    push("t3_zb1",  85, 4'b0000, OFF, 1'b0, 1'b0);
    push("t3_zb2",  89, 4'b0000, OFF, 1'b0, 1'b0);
    push("t3_zb3",  93, 4'b0000, OFF, 1'b0, 1'b0);
    offer(65, 16'h0000, 1);

    // Offer while a word is pending must be ignored
    ld_q.push_back(base + 96);
    push("t4_d8", 97,  4'b0001, 7'b0000000, 1'b0, 1'b0);
    push("t4_d7", 101, 4'b0010, 7'b0001111, 1'b0, 1'b0);
    push("t4_d6", 105, 4'b0100, 7'b0100000, 1'b0, 1'b0);
    push("t4_d5", 109, 4'b1000, 7'b0100100, 1'b0, 1'b0);
    offer(81, 16'h5678, 1);
    offer(85, 16'h9999, 5);

    // Error pattern, then global blank mid-frame
    tick_to(base + 112);
    lz_en = 1'b0;
    ld_q.push_back(base + 128);
    push("t5_err",    129, 4'b0001, 7'b0110110, 1'b0, 1'b0);
    push("t5_pre",    134, 4'b0010, 7'b0000001, 1'b0, 1'b0);
    push("t5_blank",  135, 4'b0000, OFF, 1'b0, 1'b0);
    push("t5_blank",  140, 4'b0000, OFF, 1'b0, 1'b0);
    push("t5_resume", 141, 4'b1000, 7'b0000001, 1'b0, 1'b0);
    offer(112, 16'h000A, 1);
    tick_to(base + 134);
    blank = 1'b1;
    tick_to(base + 140);
    blank = 1'b0;

    // Reset with a word pending: it must never reach the display
    push("t6_pend", 147, 4'b0001, 7'b0110110, 1'b1, 1'b0);
    offer(145, 16'h4321, 1);
    tick_to(base + 150);
    do_reset();
    push("t6_scan", 1,  4'b0001, 7'b0000001, 1'b1, 1'b1);
    push("t6_fend", 16, 4'b1000, 7'b0000001, 1'b1, 1'b1);
    push("t6_keep", 17, 4'b0001, 7'b0000001, 1'b0, 1'b0);
    push("t6_keep", 29, 4'b1000, 7'b0000001, 1'b0, 1'b0);
    tick_to(base + 40);

    foreach (sb[i]) begin
      compared++;
      mismatched++;
      $display("FAIL %0s: check at %0d never reached", sb[i].tag, sb[i].at);
    end
    foreach (ld_q[i]) begin
      compared++;
      mismatched++;
      $display("FAIL loaded_missing: no pulse at cycle %0d", ld_q[i]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
